mult_window_avg: RTL

Downstream consumer of the constant-multiplier pipeline's 20-bit product stream `y`. Keeps a sliding window of the last 2^WIN_LOG2 accepted products and reports the running window sum, the truncated window average and the running maximum. It sits directly after the multiplier pipeline stage, and its valid-qualified input is driven by that stage's output register.

---
 rtl/mult_window_avg.sv | 105 ++++++++++
 1 files changed

// File: rtl/mult_window_avg.sv
// mult_window_avg: sliding-window sum, average and running max over the multiplier's product stream.
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   clear     : synchronous flush of window, sum, max and counters (wins over in_valid)
//   in_valid  : in_data carries a new sample this cycle
//   in_data   : unsigned product sample
//   out_valid : one-cycle pulse when the outputs reflect a full window
//   out_sum   : sum of the last 2^WIN_LOG2 samples
//   out_avg   : out_sum >> WIN_LOG2, truncating
//   out_max   : largest sample since reset or clear
//   full      : window holds 2^WIN_LOG2 samples
module mult_window_avg #(
    parameter int DATA_W   = 20,
    parameter int WIN_LOG2 = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    output logic [DATA_W+WIN_LOG2-1:0] out_sum,
    output logic [DATA_W-1:0]          out_avg,
    output logic [DATA_W-1:0]          out_max,
    output logic                       full
);
    localparam int DEPTH = 1 << WIN_LOG2;
    localparam int ACC_W = DATA_W + WIN_LOG2;
    localparam int FILL_W = WIN_LOG2 + 1;

    typedef enum logic {FILL, RUN} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [DATA_W-1:0]     r_buf [DEPTH];
    logic [WIN_LOG2-1:0]   r_wr_ptr;
    logic [FILL_W-1:0]     r_fill;
    logic [ACC_W-1:0]      r_acc;
    logic [DATA_W-1:0]     r_max;
    logic                  r_pend;
    logic                  w_accept;
    logic                  w_run;

    assign w_accept = in_valid && !clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= FILL;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (clear)
            w_next_state = FILL;
        else if (r_state == FILL && in_valid && r_fill == FILL_W'(DEPTH - 1))
            w_next_state = RUN;
    end

    always_comb w_run = (r_state == RUN);

    // Window state updates on the accepting edge; the output registers copy it
    // one edge later, which gives the one-cycle latency and holds values between samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf     <= '{default: '0};
            r_wr_ptr  <= '0;
            r_fill    <= '0;
            r_acc     <= '0;
            r_max     <= '0;
            r_pend    <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_avg   <= '0;
            out_max   <= '0;
            full      <= 1'b0;
        end else if (clear) begin
            r_buf     <= '{default: '0};
            r_wr_ptr  <= '0;
            r_fill    <= '0;
            r_acc     <= '0;
            r_max     <= '0;
            r_pend    <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_avg   <= '0;
            out_max   <= '0;
            full      <= 1'b0;
        end else begin
            if (w_accept) begin
                // Empty slots hold zero, so the subtraction is exact while filling.
                r_acc           <= r_acc + ACC_W'(in_data) - ACC_W'(r_buf[r_wr_ptr]);
                r_buf[r_wr_ptr] <= in_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
                r_fill          <= (r_fill == FILL_W'(DEPTH)) ? r_fill : r_fill + 1'b1;
                r_max           <= (in_data > r_max) ? in_data : r_max;
            end
            r_pend    <= w_accept && (w_next_state == RUN);
            out_valid <= r_pend;
            out_sum   <= r_acc;
            out_avg   <= DATA_W'(r_acc >> WIN_LOG2);
            out_max   <= r_max;
            full      <= w_run;
        end
    end
endmodule
